// File: rtl/swizzle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : swizzle_pkg
// Purpose  : Shared defaults and FSM state encoding for the swizzle
//            passthrough blocks (dram_to_cram and cram_to_dram).
// Revision : 1.0 - initial release
// ============================================================================
package swizzle_pkg;

  localparam int DEFAULT_DWIDTH     = 40;
  localparam int DEFAULT_AWIDTH     = 9;
  localparam int DEFAULT_NUMW       = 16;
  localparam int DEFAULT_NUM_WORDS  = 512;
  localparam int DEFAULT_START_ADDR = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : swizzle_pkg
`default_nettype wire

// File: rtl/swizzle_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : swizzle_out_fifo
// Purpose  : Small synchronous FIFO holding RAM read data until the memory
//            controller accepts it. Depth must be a power of two, so the
//            read/write pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module swizzle_out_fifo #(
  parameter int DWIDTH     = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push,
  input  logic [DWIDTH-1:0]             push_data,
  input  logic                          pop,
  output logic [DWIDTH-1:0]             head,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DWIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(FIFO_DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : swizzle_out_fifo
`default_nettype wire

// File: rtl/swizzle_cram_to_dram.sv
`default_nettype none
// ============================================================================
// Module   : swizzle_cram_to_dram
// Purpose  : Reads num_rams compute RAMs word by word and streams the words
//            to the memory controller through a credit-managed output FIFO.
//            A read is issued only when the FIFO is guaranteed room for its
//            data, so controller backpressure never drops or repeats a word.
// Revision : 1.0 - initial release
// ============================================================================
module swizzle_cram_to_dram
  import swizzle_pkg::*;
#(
  parameter int DWIDTH     = DEFAULT_DWIDTH,
  parameter int AWIDTH     = DEFAULT_AWIDTH,
  parameter int NUM_WORDS  = DEFAULT_NUM_WORDS,
  parameter int START_ADDR = DEFAULT_START_ADDR,
  parameter int NUMW       = DEFAULT_NUMW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [NUMW-1:0]   num_rams,
  input  logic [DWIDTH-1:0] ram_data_in,
  output logic              ram_re,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [NUMW-1:0]   ram_num,
  output logic [DWIDTH-1:0] mem_ctrl_data_out,
  output logic              mem_ctrl_data_valid,
  input  logic              mem_ctrl_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic              ram_re_q, ram_re_d;
  logic [AWIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [NUMW-1:0]   ram_num_q, ram_num_d;
  logic [NUMW-1:0]   num_rams_q, num_rams_d;
  logic              inflight_q, inflight_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic [CNTW-1:0]   fifo_count;
  logic              pop;
  logic [CNTW:0]     credit_sum;
  logic              credit_ok;
  logic              last_addr;
  logic              last_read;
  logic              drain_clear;

  swizzle_out_fifo #(
    .DWIDTH     (DWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (inflight_q),
    .push_data (ram_data_in),
    .pop       (pop),
    .head      (mem_ctrl_data_out),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign mem_ctrl_data_valid = !fifo_empty;
  assign pop                 = !fifo_empty && mem_ctrl_ready;

  // Words committed for next cycle: FIFO contents plus landing and issuing
  // reads, minus this cycle's pop. Another read fits only below the depth.
  assign credit_sum = {1'b0, fifo_count} + (CNTW+1)'(inflight_q)
                    + (CNTW+1)'(ram_re_q) - (CNTW+1)'(pop);
  assign credit_ok  = (credit_sum < (CNTW+1)'(FIFO_DEPTH)) && !(fifo_full && !pop);

  assign last_addr   = (ram_addr_q == AWIDTH'(NUM_WORDS - 1));
  assign last_read   = ram_re_q && last_addr && (ram_num_q == (num_rams_q - NUMW'(1)));
  // FIFO will be empty after this cycle and nothing is still arriving.
  assign drain_clear = !inflight_q &&
                       (fifo_empty || ((fifo_count == CNTW'(1)) && pop));

  // Next-state and registered-output computation for the read sequencer.
  always_comb begin
    state_d    = state_q;
    ram_re_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_num_d  = ram_num_q;
    num_rams_d = num_rams_q;
    inflight_d = ram_re_q;
    busy_d     = busy_q;
    done_d     = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
          num_rams_d = num_rams;
          busy_d     = 1'b1;
          if (num_rams != '0) begin
            state_d    = READ;
            ram_num_d  = '0;
            ram_addr_d = AWIDTH'(START_ADDR);
            ram_re_d   = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        if (ram_re_q) begin
          if (last_addr) begin
            ram_addr_d = AWIDTH'(START_ADDR);
            ram_num_d  = ram_num_q + NUMW'(1);
          end else begin
            ram_addr_d = ram_addr_q + AWIDTH'(1);
          end
        end
        if (last_read) begin
          state_d = DRAIN;
        end else begin
          ram_re_d = credit_ok;
        end
      end
      DRAIN: begin
        if (drain_clear) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered outputs; reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      ram_re_q   <= 1'b0;
      ram_addr_q <= AWIDTH'(START_ADDR);
      ram_num_q  <= '0;
      num_rams_q <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_re_q   <= ram_re_d;
      ram_addr_q <= ram_addr_d;
      ram_num_q  <= ram_num_d;
      num_rams_q <= num_rams_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ram_re   = ram_re_q;
  assign ram_addr = ram_addr_q;
  assign ram_num  = ram_num_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule : swizzle_cram_to_dram
`default_nettype wire

// File: tb/tb_swizzle_cram_to_dram.sv
`default_nettype none
// ============================================================================
// Module   : tb_swizzle_cram_to_dram
// Purpose  : Directed bench for swizzle_cram_to_dram. The RAM model returns
//            {ram_num, ram_addr} one cycle after each read, so every beat's
//            expected value follows from its position in the stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swizzle_cram_to_dram;

  localparam int DW = 40;
  localparam int AW = 9;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [NW-1:0] num_rams;
  logic [DW-1:0] ram_data_in;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [NW-1:0] ram_num;
  logic [DW-1:0] mem_ctrl_data_out;
  logic          mem_ctrl_data_valid;
  logic          mem_ctrl_ready;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  swizzle_cram_to_dram dut (
    .clk                 (clk),
    .resetn              (resetn),
    .start               (start),
    .num_rams            (num_rams),
    .ram_data_in         (ram_data_in),
    .ram_re              (ram_re),
    .ram_addr            (ram_addr),
    .ram_num             (ram_num),
    .mem_ctrl_data_out   (mem_ctrl_data_out),
    .mem_ctrl_data_valid (mem_ctrl_data_valid),
    .mem_ctrl_ready      (mem_ctrl_ready),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, junk when no read was issued.
  always @(posedge clk) begin
    if (ram_re) ram_data_in <= DW'({ram_num, ram_addr});
    else        ram_data_in <= 40'hBADBADBAD0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer starting this cycle. mode 0: ready=1; mode 1: ready
  // toggles 1010 with a 20-cycle stall. abort_beat>=0 stalls after that many
  // beats until the FIFO is full, then resets. extra_start>=0 pulses a
  // second start (num_rams=3) at that cycle.
  task automatic run_xfer(input string tag, input int n, input int mode,
                          input int abort_beat, input int extra_start);
    int c, beats, issued, commit, max_commit, first_valid, done_cyc, stall;
    bit fin, aborted, prev_stalled, prev_re;
    logic [DW-1:0] prev_data, exp_d;
    logic [AW-1:0] prev_addr;
    logic [NW-1:0] prev_num;
    c = 0; beats = 0; issued = 0; max_commit = 0; first_valid = -1;
    done_cyc = -1; stall = 0; fin = 0; aborted = 0;
    prev_stalled = 0; prev_re = 0; prev_data = '0; prev_addr = '0; prev_num = '0;
    while (c < 4000) begin
      start    = (c == 0) || (c == extra_start);
      num_rams = (c == extra_start) ? NW'(3) : NW'(n);
      if (abort_beat >= 0 && beats >= abort_beat) mem_ctrl_ready = 1'b0;
      else if (mode == 1) mem_ctrl_ready = (c >= 300 && c < 320) ? 1'b0 : (c % 2 == 0);
      else mem_ctrl_ready = 1'b1;

      if (c == 0) begin
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
      end
      if (c == 1) begin
        chk({tag, "_re_at_1"}, ram_re, 1);
        chk({tag, "_addr_at_1"}, ram_addr, 0);
        chk({tag, "_busy_at_1"}, busy, 1);
      end
      if (ram_re) issued++;
      commit = issued - beats;
      if (commit > max_commit) max_commit = commit;
      if (mode == 1 && c == 319) begin
        chk({tag, "_stall_re_off"}, ram_re, 0);
        chk({tag, "_stall_credits"}, commit, 4);
      end
      if (prev_stalled) begin
        chk({tag, "_hold_valid"}, mem_ctrl_data_valid, 1);
        chk({tag, "_hold_data"}, mem_ctrl_data_out, prev_data);
      end
      if (prev_re && prev_addr == AW'(511)) begin
        chk({tag, "_wrap_addr"}, ram_addr, 0);
        chk({tag, "_wrap_num"}, ram_num, NW'(prev_num + NW'(1)));
      end
      if (mem_ctrl_data_valid && first_valid < 0) first_valid = c;
      if (done) begin
        done_cyc = c;
        chk({tag, "_busy_at_done"}, busy, 0);
        fin = 1;
      end
      if (mem_ctrl_data_valid && mem_ctrl_ready) begin
        exp_d = DW'({NW'(beats / 512), AW'(beats % 512)});
        chk({tag, "_beat_data"}, mem_ctrl_data_out, exp_d);
        beats++;
      end
      if (abort_beat >= 0 && beats >= abort_beat) begin
        stall++;
        if (stall == 12) begin
          chk({tag, "_full_valid"}, mem_ctrl_data_valid, 1);
          chk({tag, "_full_credits"}, commit, 4);
          resetn = 1'b0;
          start  = 1'b0;
          step();
          chk({tag, "_rst_re"}, ram_re, 0);
          chk({tag, "_rst_valid"}, mem_ctrl_data_valid, 0);
          chk({tag, "_rst_busy"}, busy, 0);
          chk({tag, "_rst_addr"}, ram_addr, 0);
          chk({tag, "_rst_done"}, done, 0);
          resetn = 1'b1;
          for (int k = 0; k < 4; k++) begin
            step();
            chk({tag, "_post_rst_done"}, done, 0);
            chk({tag, "_post_rst_valid"}, mem_ctrl_data_valid, 0);
          end
          aborted = 1;
          fin     = 1;
        end
      end
      if (fin) break;
      prev_stalled = mem_ctrl_data_valid && !mem_ctrl_ready;
      prev_data    = mem_ctrl_data_out;
      prev_re      = ram_re;
      prev_addr    = ram_addr;
      prev_num     = ram_num;
      step();
      c++;
    end
    start = 1'b0;
    chk({tag, "_finished_in_budget"}, fin, 1);
    if (!aborted) begin
      chk({tag, "_beats"}, beats, 512 * n);
      chk({tag, "_max_fifo"}, (max_commit <= 4), 1);
      if (mode == 0) begin
        chk({tag, "_first_valid"}, first_valid, 3);
        chk({tag, "_done_cycle"}, done_cyc, 512 * n + 4);
      end
    end
  endtask

  initial begin
    resetn         = 1'b0;
    start          = 1'b0;
    num_rams       = '0;
    mem_ctrl_ready = 1'b0;
    step();
    step();
    chk("reset_re", ram_re, 0);
    chk("reset_addr", ram_addr, 0);
    chk("reset_num", ram_num, 0);
    chk("reset_valid", mem_ctrl_data_valid, 0);
    chk("reset_data", mem_ctrl_data_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    resetn = 1'b1;
    step();

    run_xfer("one_ram", 1, 0, -1, -1);
    step();
    run_xfer("two_rams", 2, 0, -1, -1);
    step();
    run_xfer("toggle", 1, 1, -1, -1);
    step();

    // Zero-RAM transfer: straight to the done pulse two cycles later.
    mem_ctrl_ready = 1'b1;
    start          = 1'b1;
    num_rams       = '0;
    step();
    start = 1'b0;
    chk("zero_busy_c1", busy, 1);
    chk("zero_done_c1", done, 0);
    chk("zero_re_c1", ram_re, 0);
    step();
    chk("zero_done_c2", done, 1);
    chk("zero_busy_c2", busy, 0);
    chk("zero_re_c2", ram_re, 0);
    chk("zero_valid_c2", mem_ctrl_data_valid, 0);
    step();
    chk("zero_done_c3", done, 0);
    chk("zero_valid_c3", mem_ctrl_data_valid, 0);
    step();

    run_xfer("abort", 1, 0, 100, -1);
    run_xfer("after_reset", 1, 0, -1, -1);
    step();
    run_xfer("ignore_start", 1, 0, -1, 50);
    step();
    run_xfer("back_to_back", 1, 0, -1, -1);
    step();
    chk("final_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_swizzle_cram_to_dram
`default_nettype wire
